// File: rtl/sr_fpu_pkg.sv
// Shared definitions for the stochastic-rounding FPU datapath: LFSR polynomial,
// default seed and the normalize->round stage payload.
package sr_fpu_pkg;

  // x^16 + x^14 + x^13 + x^11 + 1, taps on state bits 15, 13, 12, 10.
  localparam logic [15:0] LfsrTaps        = 16'hB400;
  localparam logic [15:0] LfsrDefaultSeed = 16'hACE1;

  // Payload fields are sized for the widest supported configuration.
  localparam int unsigned MaxExpW  = 16;
  localparam int unsigned MaxNormW = 128;

  typedef struct packed {
    logic                sign;
    logic                zero;
    logic [MaxExpW-1:0]  exp_n;
    logic [MaxNormW-1:0] norm;
  } s1_payload_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LfsrTaps)};
  endfunction

endpackage

// File: rtl/sr_lfsr.sv
// 16-bit Fibonacci LFSR that steps only when enabled; supplies rounding randomness.
module sr_lfsr
  import sr_fpu_pkg::*;
#(
  parameter logic [15:0] Seed = LfsrDefaultSeed
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/sr_norm_round.sv
// Two-stage normalize/round stage. Round-to-nearest-even by default; define
// SR_STOCHASTIC_EN for LFSR-driven stochastic rounding.
module sr_norm_round
  import sr_fpu_pkg::*;
#(
  parameter int unsigned round_bits_surp = 4,
  parameter int unsigned exp_width       = 8,
  parameter int unsigned mant_width      = 23,
  parameter logic [15:0] LFSR_SEED       = LfsrDefaultSeed
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      in_sign,
  input  logic [exp_width+1:0]                      in_exp,
  input  logic [2*mant_width+3+round_bits_surp-1:0] in_mant,
  input  logic [exp_width+1:0]                      in_lz,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_sign,
  output logic [exp_width-1:0]                      out_exp,
  output logic [mant_width-1:0]                     out_mant,
  output logic                                      out_ovf,
  output logic                                      out_unf,
  output logic                                      out_inexact
);

  localparam int unsigned W     = 2 * mant_width + 3 + round_bits_surp;
  localparam int unsigned EW    = exp_width + 2;
  localparam int unsigned TailW = W - 1 - mant_width;
  localparam logic [EW:0] ExpAllOnes = {3'b000, {exp_width{1'b1}}};

  logic        s1_valid_q, s1_valid_d;
  s1_payload_t s1_q, s1_d;
  logic        advance, s1_xfer;

  logic                  out_valid_q, out_valid_d;
  logic                  out_sign_q, out_sign_d;
  logic [exp_width-1:0]  out_exp_q, out_exp_d;
  logic [mant_width-1:0] out_mant_q, out_mant_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  out_unf_q, out_unf_d;
  logic                  out_inexact_q, out_inexact_d;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || advance;
  assign s1_xfer  = s1_valid_q && advance;

  // S1: normalize
  logic [W-1:0]  norm;
  logic [EW-1:0] exp_n;

  always_comb begin
    norm       = in_mant << in_lz;
    exp_n      = in_exp + EW'(1) - in_lz;
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.sign  = in_sign;
        s1_d.zero  = (in_mant == '0);
        s1_d.exp_n = MaxExpW'($signed(exp_n));
        s1_d.norm  = MaxNormW'(norm);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  // S2: round
  logic [W-1:0]               s2_norm;
  logic [EW-1:0]              s2_exp;
  logic [mant_width-1:0]      kept;
  logic [TailW-1:0]           tail;
  logic [round_bits_surp-1:0] rbits;
  logic                       sticky;
  logic                       round_up;
  logic [mant_width:0]        kept_r;
  logic [EW:0]                exp_f;
  logic                       ovf, unf;
  logic                       unused_s1;

  assign s2_norm   = s1_q.norm[W-1:0];
  assign s2_exp    = s1_q.exp_n[EW-1:0];
  assign kept      = s2_norm[W-2 -: mant_width];
  assign tail      = s2_norm[TailW-1:0];
  assign rbits     = tail[TailW-1 -: round_bits_surp];
  assign sticky    = |tail[TailW-1-round_bits_surp:0];
  assign unused_s1 = ^{s1_q.norm[MaxNormW-1:W], s1_q.exp_n[MaxExpW-1:EW]};

`ifdef SR_STOCHASTIC_EN
  logic [15:0]              lfsr_state;
  logic [round_bits_surp:0] rnd_sum;
  logic                     unused_lfsr;

  sr_lfsr #(
    .Seed (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (s1_xfer),
    .state_o (lfsr_state)
  );

  // Carry out of R + rnd decides the round-up; sticky does not participate.
  assign rnd_sum     = {1'b0, rbits} + {1'b0, lfsr_state[round_bits_surp-1:0]};
  assign round_up    = rnd_sum[round_bits_surp];
  assign unused_lfsr = ^lfsr_state;
`else
  logic [15:0] unused_seed;

  assign round_up    = tail[TailW-1] & ((|tail[TailW-2:0]) | kept[0]);
  assign unused_seed = LFSR_SEED;
`endif

  assign kept_r = {1'b0, kept} + {{mant_width{1'b0}}, round_up};
  // Sign-extended one bit so a rounding carry cannot wrap the exponent.
  assign exp_f  = {s2_exp[EW-1], s2_exp} + (EW + 1)'(kept_r[mant_width]);
  assign ovf    = $signed(exp_f) >= $signed(ExpAllOnes);
  assign unf    = exp_f[EW] || (exp_f == '0);

  always_comb begin
    out_valid_d   = out_valid_q;
    out_sign_d    = out_sign_q;
    out_exp_d     = out_exp_q;
    out_mant_d    = out_mant_q;
    out_ovf_d     = out_ovf_q;
    out_unf_d     = out_unf_q;
    out_inexact_d = out_inexact_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
    end
    if (s1_xfer) begin
      out_sign_d    = s1_q.sign;
      out_exp_d     = '0;
      out_mant_d    = '0;
      out_ovf_d     = 1'b0;
      out_unf_d     = 1'b0;
      out_inexact_d = 1'b0;
      if (s1_q.zero) begin
        out_exp_d = '0;
      end else if (ovf) begin
        out_exp_d     = '1;
        out_ovf_d     = 1'b1;
        out_inexact_d = 1'b1;
      end else if (unf) begin
        out_unf_d     = 1'b1;
        out_inexact_d = 1'b1;
      end else begin
        out_exp_d     = exp_f[exp_width-1:0];
        out_mant_d    = kept_r[mant_width-1:0];
        out_inexact_d = (rbits != '0) || sticky;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_sign_q    <= 1'b0;
      out_exp_q     <= '0;
      out_mant_q    <= '0;
      out_ovf_q     <= 1'b0;
      out_unf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_sign_q    <= out_sign_d;
      out_exp_q     <= out_exp_d;
      out_mant_q    <= out_mant_d;
      out_ovf_q     <= out_ovf_d;
      out_unf_q     <= out_unf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sign    = out_sign_q;
  assign out_exp     = out_exp_q;
  assign out_mant    = out_mant_q;
  assign out_ovf     = out_ovf_q;
  assign out_unf     = out_unf_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_sr_norm_round.sv
// Directed-vector bench for sr_norm_round (exp_width=8, mant_width=23, round_bits_surp=4).
module tb_sr_norm_round;

  localparam int W = 53;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_sign;
  logic [9:0]    in_exp, in_lz;
  logic [W-1:0]  in_mant;
  logic          out_valid, out_ready, out_sign;
  logic [7:0]    out_exp;
  logic [22:0]   out_mant;
  logic          out_ovf, out_unf, out_inexact;

  always #5 clk = ~clk;

  sr_norm_round dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .in_lz       (in_lz),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_exp     (out_exp),
    .out_mant    (out_mant),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
  );

  typedef struct {
    string        name;
    logic         sign;
    logic [9:0]   exp;
    logic [W-1:0] mant;
    logic [9:0]   lz;
    logic [7:0]   x_exp;
    logic [22:0]  x_mant;
    logic         x_ovf;
    logic         x_unf;
    logic         x_inx;
  } vec_t;

  vec_t vecs[$];
  vec_t stall_v[3];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [W-1:0] pm(input logic [22:0] kept, input logic [3:0] r,
                                      input logic [24:0] st);
    return {1'b1, kept, r, st};
  endfunction

  function automatic vec_t mk(input string nm, input logic s, input logic [9:0] e,
                              input logic [W-1:0] m, input logic [9:0] lz,
                              input logic [7:0] xe, input logic [22:0] xm,
                              input logic xo, input logic xu, input logic xi);
    vec_t v;
    v.name = nm; v.sign = s; v.exp = e; v.mant = m; v.lz = lz;
    v.x_exp = xe; v.x_mant = xm; v.x_ovf = xo; v.x_unf = xu; v.x_inx = xi;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    in_sign = v.sign;
    in_exp  = v.exp;
    in_mant = v.mant;
    in_lz   = v.lz;
  endtask

  // Single transaction with out_ready held high; checks latency and all outputs.
  task automatic do_op(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    chk({v.name, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (n < 10 && !out_valid) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, " latency"}, 64'(n), 64'd2);
    chk({v.name, " exp"}, 64'(out_exp), 64'(v.x_exp));
    chk({v.name, " mant"}, 64'(out_mant), 64'(v.x_mant));
    chk({v.name, " sign"}, 64'(out_sign), 64'(v.sign));
    chk({v.name, " flags"}, 64'({out_ovf, out_unf, out_inexact}),
        64'({v.x_ovf, v.x_unf, v.x_inx}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  held_exp;
    logic [22:0] held_mant;
    logic        have_held, rdy;
    int          idx, nrec, seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_lz = '0;

    vecs.push_back(mk("basic",   0, 10'd127, pm(0, 0, 0), 0,          8'd128, 0,        0, 0, 0));
    vecs.push_back(mk("zero",    0, 10'd127, '0, 10'd5,               8'd0,   0,        0, 0, 0));
    vecs.push_back(mk("exact",   1, 10'd127, pm(23'h5, 0, 0), 0,      8'd128, 23'h5,    0, 0, 0));
    vecs.push_back(mk("norm_lz", 0, 10'd130, pm(23'h123456, 0, 0) >> 4, 10'd4,
                      8'd127, 23'h123456, 0, 0, 0));
    vecs.push_back(mk("exp_254", 0, 10'd253, pm(0, 0, 0), 0,          8'd254, 0,        0, 0, 0));
    vecs.push_back(mk("ovf_255", 1, 10'd254, pm(0, 0, 0), 0,          8'hFF,  0,        1, 0, 1));
    vecs.push_back(mk("ovf_300", 0, 10'd300, pm(23'h55, 0, 0), 0,     8'hFF,  0,        1, 0, 1));
    vecs.push_back(mk("exp_1",   0, 10'd0,   pm(23'h7, 0, 0), 0,      8'd1,   23'h7,    0, 0, 0));
    vecs.push_back(mk("unf_0",   0, 10'h3FF, pm(23'h7, 0, 0), 0,      8'd0,   0,        0, 1, 1));
    vecs.push_back(mk("unf_m5",  1, 10'h3FB, pm(0, 0, 0), 0,          8'd0,   0,        0, 1, 1));
`ifndef SR_STOCHASTIC_EN
    vecs.push_back(mk("tie_even",  0, 10'd127, pm(23'h2, 4'b1000, 0), 0, 8'd128, 23'h2, 0, 0, 1));
    vecs.push_back(mk("tie_odd",   0, 10'd127, pm(23'h3, 4'b1000, 0), 0, 8'd128, 23'h4, 0, 0, 1));
    vecs.push_back(mk("above_hlf", 0, 10'd127, pm(23'h2, 4'b1000, 1), 0, 8'd128, 23'h3, 0, 0, 1));
    vecs.push_back(mk("below_hlf", 0, 10'd127, pm(23'h5, 4'b0111, 0), 0, 8'd128, 23'h5, 0, 0, 1));
    vecs.push_back(mk("sticky",    0, 10'd127, pm(23'h5, 4'b0000, 25'h100), 0,
                      8'd128, 23'h5, 0, 0, 1));
    vecs.push_back(mk("carry",     0, 10'd127, pm(23'h7FFFFF, 4'b1100, 0), 0,
                      8'd129, 23'h0, 0, 0, 1));
    vecs.push_back(mk("carry_ovf", 0, 10'd253, pm(23'h7FFFFF, 4'b1100, 0), 0,
                      8'hFF, 23'h0, 1, 0, 1));
`endif
    for (int i = 0; i < 3; i++) begin
      stall_v[i] = mk($sformatf("stall%0d", i), 0, 10'(120 + i), pm(23'(i + 1), 0, 0), 0,
                      8'(121 + i), 23'(i + 1), 0, 0, 0);
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst data", 64'({out_sign, out_exp, out_mant, out_ovf, out_unf, out_inexact}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) do_op(vecs[i]);

    // Backpressure: two accepted, outputs frozen, then drained in order.
    idx = 0; have_held = 1'b0; held_exp = '0; held_mant = '0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) begin
        if (!have_held) begin
          held_exp = out_exp; held_mant = out_mant; have_held = 1'b1;
          chk("stall first exp", 64'(out_exp), 64'd121);
        end else begin
          chk("stall hold exp", 64'(out_exp), 64'(held_exp));
          chk("stall hold mant", 64'(out_mant), 64'(held_mant));
        end
      end
      in_valid = (idx < 3);
      if (idx < 3) drive(stall_v[idx]);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy && in_valid) idx++;
    end
    @(negedge clk);
    chk("stall accepted", 64'(idx), 64'd2);
    chk("stall in_ready", 64'(in_ready), 64'd0);
    chk("stall out_valid", 64'(out_valid), 64'd1);
    chk("stall held", 64'(have_held), 64'd1);
    out_ready = 1'b1;
    nrec = 0;
    for (int c = 0; c < 20 && nrec < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) begin
        chk($sformatf("order%0d exp", nrec), 64'(out_exp), 64'(121 + nrec));
        chk($sformatf("order%0d mant", nrec), 64'(out_mant), 64'(nrec + 1));
        nrec++;
      end
      in_valid = (idx < 3);
      if (idx < 3) drive(stall_v[idx]);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy && in_valid) idx++;
    end
    in_valid = 1'b0;
    chk("drain count", 64'(nrec), 64'd3);

    // Reset with an item in flight discards it.
    @(negedge clk);
    drive(stall_v[0]);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst no output", 64'(seen), 64'd0);

`ifdef SR_STOCHASTIC_EN
    begin
      logic [15:0] s;
      int          up_dut, up_model;
      do_reset();
      s = 16'hACE1;
      for (int i = 0; i < 20; i++) begin
        do_op(mk("sr_r0", 0, 10'd127, pm(23'h2, 0, 0), 0, 8'd128, 23'h2, 0, 0, 0));
        s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      end
      up_dut = 0; up_model = 0;
      for (int i = 0; i < 1000; i++) begin
        logic [4:0] sum;
        sum = {1'b0, s[3:0]} + 5'd8;
        up_model += int'(sum[4]);
        do_op(mk("sr_r8", 0, 10'd127, pm(23'h2, 4'b1000, 0), 0, 8'd128,
                 sum[4] ? 23'h3 : 23'h2, 0, 0, 1));
        if (out_mant == 23'h3) up_dut++;
        s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      end
      chk("sr round-up count", 64'(up_dut), 64'(up_model));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sr_norm_round.md
SR_NORM_ROUND -- requirements
Module: sr_norm_round

Interface
REQ-001 SHALL have parameter round_bits_surp, default 4, random/guard bits used for rounding (1..16).
REQ-002 SHALL have parameter exp_width, default 8, result exponent width.
REQ-003 SHALL have parameter mant_width, default 23, result fraction width (hidden bit excluded).
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-005 SHALL have ports, where W = 2*mant_width+3+round_bits_surp:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  stage can accept.
- in_sign  in  1  result sign.
- in_exp  in  exp_width+2  signed biased exponent of unnormalized product.
- in_mant  in  W  unnormalized product mantissa; MSB weight 2^1.
- in_lz  in  exp_width+2  leading-zero count of in_mant from the upstream clz stage.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream can accept.
- out_sign  out  1  result sign.
- out_exp  out  exp_width  biased result exponent.
- out_mant  out  mant_width  result fraction.
- out_ovf, out_unf, out_inexact  out  1 each  exception flags.

Function
REQ-006 SHALL be a 2-stage pipeline: S1 normalizes, S2 rounds and registers outputs; latency 2 cycles from in_valid&&in_ready to out_valid.
REQ-007 SHALL transfer on valid&&ready only; in_ready = !s1_valid || S1 advancing; S1 advances when !out_valid || out_ready.
REQ-008 SHALL hold all out_* stable while out_valid && !out_ready, and preserve issue order; no drops, no duplicates.
REQ-009 S1 SHALL compute norm = in_mant << in_lz (W bits) and exp_n = in_exp + 1 - in_lz (signed, exp_width+2 bits).
REQ-010 S2 SHALL take kept = norm[W-2 -: mant_width], R = next round_bits_surp bits, sticky = OR of remaining bits.
REQ-011 S2 SHALL round up kept by 1 per the rounding mode in the Configuration section.
REQ-012 On kept overflow from rounding, S2 SHALL output mant 0 and increment exp_n by 1.
REQ-013 in_mant == 0 SHALL yield exp 0, mant 0, all flags 0, regardless of in_exp/in_lz.
REQ-014 Final exp >= 2^exp_width-1 SHALL yield exp all-ones, mant 0, out_ovf=1, out_inexact=1.
REQ-015 Final exp <= 0 SHALL flush to exp 0, mant 0, out_unf=1, out_inexact=1 (no subnormals).
REQ-016 out_inexact SHALL be (R != 0 || sticky) otherwise.
REQ-017 SHALL require in_lz <= W-1 for nonzero in_mant; in_lz > W-1 is unsupported.

Reset
REQ-018 rst_n low SHALL asynchronously clear s1_valid, out_valid, all out_* data and flags to 0, and load LFSR with LFSR_SEED.
REQ-019 Reset mid-operation SHALL discard all in-flight items; first valid output after release requires a new input.
REQ-020 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-021 With SR_STOCHASTIC_EN defined: round up iff R + rnd >= 2^round_bits_surp, rnd = LFSR[round_bits_surp-1:0]; sticky ignored for the decision.
REQ-022 Without SR_STOCHASTIC_EN: round-to-nearest-even on guard = R MSB, rest = (R lower bits | sticky), lsb = kept[0]; LFSR not instantiated.
REQ-023 LFSR SHALL advance exactly once per S1->S2 transfer, never on stall.

Structure
REQ-024 Shared package sr_fpu_pkg SHALL hold the LFSR polynomial (x^16+x^14+x^13+x^11+1), default seed, and the S1->S2 payload struct typedef.
REQ-025 Sub-module sr_lfsr (16-bit Fibonacci, enable input, async active-low reset) SHALL supply rnd.

Verification (exp_width=8, mant_width=23, round_bits_surp=4)
REQ-026 in_mant=1<<52, in_exp=127, in_lz=0, out_ready=1 -> 2 cycles later exp=128, mant=0, flags 0.
REQ-027 No macro: kept=0x000002, R=4'b1000, sticky=0 -> mant 0x000002; kept=0x000003 -> 0x000004; inexact=1 both.
REQ-028 kept=0x7FFFFF, R=4'b1100, no macro -> mant 0, exp incremented by 1.
REQ-029 in_exp=300, in_lz=0 -> exp=0xFF, mant 0, ovf=1; in_exp=-5 -> exp 0, unf=1.
REQ-030 out_ready=0 for 5 cycles, 3 inputs offered back-to-back -> 2 accepted, in_ready=0, out_* constant; on release 3 results in order.
REQ-031 SR_STOCHASTIC_EN, R=0, sticky=0 -> never rounds; R=4'b1000 over 1000 ops -> round-up count matches bit-exact LFSR model from LFSR_SEED.
